// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types, widths and helpers for the ID-stage hazard/forwarding controller.
// Register indices are carried zero-extended to MAX_REG_W inside the shadow scoreboard.
package pipe_ctrl_pkg;

  localparam int FWD_NONE  = 0;
  localparam int MAX_REG_W = 8;

  function automatic int reg_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  function automatic int sel_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 v;
    logic                 wr_en;
    logic [MAX_REG_W-1:0] wr_reg;
    logic                 is_load;
    logic                 hlt;
  } shadow_ent_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard controller; the pipe side is master.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 4,
  parameter int SEL_W   = 2
);
  // id_valid has no ready partner: ID is "accepted" on every edge where stall_id
  // and freeze are both low, otherwise the same instruction must be presented again.
  logic                     id_valid;
  logic [NUM_SRC-1:0]       id_rd_en;
  logic [NUM_SRC*REG_W-1:0] id_rd_reg;
  logic                     id_wr_en;
  logic [REG_W-1:0]         id_wr_reg;
  logic                     id_is_load;
  logic                     id_is_hlt;
  logic                     ex_redirect;
  logic                     mem_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall_id;
  logic                     bubble_ex;
  logic                     flush_id;
  logic                     freeze;
  logic                     halted;

  modport master (
    output id_valid, id_rd_en, id_rd_reg, id_wr_en, id_wr_reg, id_is_load, id_is_hlt,
           ex_redirect, mem_stall,
    input  fwd_sel, stall_id, bubble_ex, flush_id, freeze, halted
  );

  modport slave (
    input  id_valid, id_rd_en, id_rd_reg, id_wr_en, id_wr_reg, id_is_load, id_is_hlt,
           ex_redirect, mem_stall,
    output fwd_sel, stall_id, bubble_ex, flush_id, freeze, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Youngest-first forward selector for one read port across the downstream stages.
// Also flags a load-use hazard when any matching load is not yet forwardable.
module fwd_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int SEL_W      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                rd_en,
  input  logic [MAX_REG_W-1:0]                rd_reg,
  input  logic [DEPTH-1:0]                    cand,
  input  logic [DEPTH-1:0]                    is_load,
  input  logic [DEPTH-1:0][MAX_REG_W-1:0]     wr_reg,
  output logic [SEL_W-1:0]                    sel,
  output logic                                load_use
);

  logic             zero_src;
  logic [DEPTH-1:0] hit;

  assign zero_src = (ZERO_REG != 0) && (rd_reg == '0);

  always_comb begin
    hit      = '0;
    sel      = SEL_W'(FWD_NONE);
    load_use = 1'b0;
    // Walk oldest to youngest so the youngest (lowest stage) match is written last.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit[k] = rd_en & cand[k] & (wr_reg[k] == rd_reg) & ~zero_src;
      if (hit[k]) begin
        sel = SEL_W'(k + 1);
        if (is_load[k] && (k + 1 < LOAD_STAGE)) load_use = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: shadow scoreboard of the downstream stages,
// per-source forward selects, load-use stall/bubble, redirect flush, freeze and halt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int REG_W = reg_w(NUM_REGS);
  localparam int SEL_W = sel_w(DEPTH);

  shadow_ent_t [DEPTH-1:0]            shadow;
  shadow_ent_t [DEPTH-1:0]            shadow_next;
  shadow_ent_t                        new_ent;
  logic        [DEPTH-1:0]            cand;
  logic        [DEPTH-1:0]            ld_mask;
  logic        [DEPTH-1:0][MAX_REG_W-1:0] wr_regs;
  logic        [NUM_SRC-1:0]          lu_src;
  logic        [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                               halted;
  logic                               freeze;
  logic                               redirect;
  logic                               load_use;
  logic                               bubble_ex;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      cand[k]    = shadow[k].v & shadow[k].wr_en;
      ld_mask[k] = shadow[k].is_load;
      wr_regs[k] = shadow[k].wr_reg;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [MAX_REG_W-1:0] rd_reg_ext;
    assign rd_reg_ext = MAX_REG_W'(bus.id_rd_reg[i*REG_W +: REG_W]);

    fwd_match #(
      .DEPTH     (DEPTH),
      .SEL_W     (SEL_W),
      .LOAD_STAGE(LOAD_STAGE),
      .ZERO_REG  (ZERO_REG)
    ) u_fwd_match (
      .rd_en   (bus.id_rd_en[i]),
      .rd_reg  (rd_reg_ext),
      .cand    (cand),
      .is_load (ld_mask),
      .wr_reg  (wr_regs),
      .sel     (fwd_sel[i*SEL_W +: SEL_W]),
      .load_use(lu_src[i])
    );
  end

  // A HLT parked in the last stage freezes the shadow, so this stays set until reset.
  assign halted    = shadow[DEPTH-1].v & shadow[DEPTH-1].hlt;
  assign freeze    = bus.mem_stall | halted;
  assign load_use  = |lu_src;
  // The ID instruction is wrong-path on a redirect, so its load-use hazard is moot.
  assign redirect  = bus.ex_redirect & ~freeze;
  assign bubble_ex = ~freeze & (redirect | load_use);

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_id  = freeze | (load_use & ~redirect);
  assign bus.bubble_ex = bubble_ex;
  assign bus.flush_id  = redirect;
  assign bus.freeze    = freeze;
  assign bus.halted    = halted;

  always_comb begin
    new_ent = '0;
    if (!bubble_ex) begin
      new_ent.v       = bus.id_valid;
      new_ent.wr_en   = bus.id_wr_en;
      new_ent.wr_reg  = MAX_REG_W'(bus.id_wr_reg);
      new_ent.is_load = bus.id_is_load;
      new_ent.hlt     = bus.id_is_hlt;
    end
  end

  always_comb begin
    shadow_next    = shadow;
    shadow_next[0] = new_ent;
    for (int k = 1; k < DEPTH; k++) shadow_next[k] = shadow[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (!freeze) begin
      shadow <= shadow_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios with literal
// expectations plus a randomized run against a stage-list model of the pipe.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NUM_REGS   = 16;
  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int ZERO_REG   = 1;
  localparam int REG_W      = 4;
  localparam int SEL_W      = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .SEL_W(SEL_W)) bus ();

  pipe_hazard_ctrl #(
    .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
    .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- stimulus copies ----------------
  int t_valid, t_we, t_rd, t_ld, t_hlt, t_redir, t_stall;
  int t_en[NUM_SRC];
  int t_rs[NUM_SRC];

  // ---------------- model: list of instructions in stages 1..DEPTH ----------------
  int m_v[DEPTH+1], m_we[DEPTH+1], m_rd[DEPTH+1], m_ld[DEPTH+1], m_hlt[DEPTH+1];
  int m_halted;
  int e_sel[NUM_SRC];
  int e_stall, e_bubble, e_flush, e_freeze;

  // scoreboard of expected per-cycle output words, consumed by the compare task
  logic [NUM_SRC*SEL_W+4:0] exp_q[$];

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int valid, input int en0, input int rs0, input int en1,
                       input int rs1, input int we, input int rd, input int ld,
                       input int hlt, input int redir, input int stall);
    t_valid = valid; t_en[0] = en0; t_rs[0] = rs0; t_en[1] = en1; t_rs[1] = rs1;
    t_we = we; t_rd = rd; t_ld = ld; t_hlt = hlt; t_redir = redir; t_stall = stall;
    bus.id_valid    = valid[0];
    bus.id_rd_en    = {en1[0], en0[0]};
    bus.id_rd_reg   = {REG_W'(rs1), REG_W'(rs0)};
    bus.id_wr_en    = we[0];
    bus.id_wr_reg   = REG_W'(rd);
    bus.id_is_load  = ld[0];
    bus.id_is_hlt   = hlt[0];
    bus.ex_redirect = redir[0];
    bus.mem_stall   = stall[0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_rd[k] = 0; m_ld[k] = 0; m_hlt[k] = 0;
    end
    m_halted = 0;
  endtask

  function automatic bit writes_src(int en, int rs, int k);
    if (!en || !m_v[k] || !m_we[k]) return 0;
    if (ZERO_REG != 0 && rs == 0) return 0;
    return m_rd[k] == rs;
  endfunction

  // Outputs implied by the current stage contents and ID/EX/memory inputs.
  task automatic model_eval();
    int hazard;
    logic [NUM_SRC*SEL_W+4:0] w;
    hazard = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      e_sel[i] = 0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (writes_src(t_en[i], t_rs[i], k)) begin
          if (e_sel[i] == 0) e_sel[i] = k;
          if (m_ld[k] && k < LOAD_STAGE) hazard = 1;
        end
      end
    end
    e_freeze = (t_stall || m_halted) ? 1 : 0;
    if (e_freeze) begin
      e_stall = 1; e_bubble = 0; e_flush = 0;
    end else if (t_redir) begin
      e_stall = 0; e_bubble = 1; e_flush = 1;
    end else begin
      e_stall = hazard; e_bubble = hazard; e_flush = 0;
    end
    w = {1'(m_halted), 1'(e_freeze), 1'(e_flush), 1'(e_bubble), 1'(e_stall),
         SEL_W'(e_sel[1]), SEL_W'(e_sel[0])};
    exp_q.push_back(w);
  endtask

  task automatic model_advance();
    if (e_freeze) return;
    for (int k = DEPTH; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_rd[k] = m_rd[k-1];
      m_ld[k] = m_ld[k-1]; m_hlt[k] = m_hlt[k-1];
    end
    if (e_bubble) begin
      m_v[1] = 0; m_we[1] = 0; m_rd[1] = 0; m_ld[1] = 0; m_hlt[1] = 0;
    end else begin
      m_v[1] = t_valid; m_we[1] = t_we; m_rd[1] = t_rd; m_ld[1] = t_ld; m_hlt[1] = t_hlt;
    end
    if (m_v[DEPTH] && m_hlt[DEPTH]) m_halted = 1;
  endtask

  // Compare process body: pop the model's expectation and check every output.
  task automatic compare();
    logic [NUM_SRC*SEL_W+4:0] w;
    w = exp_q.pop_front();
    for (int i = 0; i < NUM_SRC; i++)
      cmp($sformatf("fwd_sel[%0d]", i), int'(bus.fwd_sel[i*SEL_W +: SEL_W]),
          int'(w[i*SEL_W +: SEL_W]));
    cmp("stall_id",  int'(bus.stall_id),  int'(w[NUM_SRC*SEL_W]));
    cmp("bubble_ex", int'(bus.bubble_ex), int'(w[NUM_SRC*SEL_W+1]));
    cmp("flush_id",  int'(bus.flush_id),  int'(w[NUM_SRC*SEL_W+2]));
    cmp("freeze",    int'(bus.freeze),    int'(w[NUM_SRC*SEL_W+3]));
    cmp("halted",    int'(bus.halted),    int'(w[NUM_SRC*SEL_W+4]));
  endtask

  task automatic look();
    @(negedge clk);
    model_eval();
    compare();
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("rst fwd_sel", int'(bus.fwd_sel), 0);
    cmp("rst stall_id", int'(bus.stall_id), 0);
    cmp("rst freeze", int'(bus.freeze), 0);
    cmp("rst halted", int'(bus.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int c = 0; c < DEPTH; c++) begin look(); step(); end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int halted_cycles;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    look();
    cmp("reset fwd_sel", int'(bus.fwd_sel), 0);
    cmp("reset bubble_ex", int'(bus.bubble_ex), 0);
    step();

    // 1: plain forward from stage 1
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); look(); step();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); look();
    cmp("t1 sel0", int'(bus.fwd_sel[SEL_W-1:0]), 1);
    cmp("t1 stall", int'(bus.stall_id), 0);
    step();
    drain();

    // 2: load-use, one stall then forward from stage 2
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0); look(); step();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); look();
    cmp("t2 stall", int'(bus.stall_id), 1);
    cmp("t2 bubble", int'(bus.bubble_ex), 1);
    step();
    look();
    cmp("t2 sel0 after", int'(bus.fwd_sel[SEL_W-1:0]), 2);
    cmp("t2 stall after", int'(bus.stall_id), 0);
    step();
    drain();

    // 3: youngest wins; R0 never forwards
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); look(); step();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); look(); step();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); look(); step();
    drive(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0); look();
    cmp("t3 sel1 youngest", int'(bus.fwd_sel[2*SEL_W-1:SEL_W]), 1);
    step();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    cmp("t3 sel0 r0", int'(bus.fwd_sel[SEL_W-1:0]), 0);
    step();
    drain();

    // 4: redirect beats load-use; wrong-path write never lands
    drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0); look(); step();
    drive(1, 1, 3, 0, 0, 1, 9, 0, 0, 1, 0); look();
    cmp("t4 flush", int'(bus.flush_id), 1);
    cmp("t4 bubble", int'(bus.bubble_ex), 1);
    cmp("t4 stall", int'(bus.stall_id), 0);
    step();
    drive(1, 1, 3, 1, 9, 0, 0, 0, 0, 0, 0); look();
    cmp("t4 sel1 killed", int'(bus.fwd_sel[2*SEL_W-1:SEL_W]), 0);
    cmp("t4 sel0 load", int'(bus.fwd_sel[SEL_W-1:0]), 2);
    step();
    drain();

    // 5: mem_stall with a pending load-use, then resume
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0); look(); step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1); look();
      cmp("t5 frz stall", int'(bus.stall_id), 1);
      cmp("t5 frz bubble", int'(bus.bubble_ex), 0);
      cmp("t5 frz sel0", int'(bus.fwd_sel[SEL_W-1:0]), 1);
      step();
    end
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0); look();
    cmp("t5 resume bubble", int'(bus.bubble_ex), 1);
    step();
    look();
    cmp("t5 resume sel0", int'(bus.fwd_sel[SEL_W-1:0]), 2);
    step();
    drain();

    // 6: HLT reaches the last stage after DEPTH edges, then reset clears it
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); look(); step();
    idle();
    for (int c = 1; c < DEPTH; c++) begin
      look();
      cmp("t6 not yet halted", int'(bus.halted), 0);
      step();
    end
    look();
    cmp("t6 halted", int'(bus.halted), 1);
    cmp("t6 freeze", int'(bus.freeze), 1);
    step();
    pulse_reset();

    // randomized run
    halted_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 3) != 0) ? 1 : 0,
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 199) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            ($urandom_range(0, 5) == 0) ? 1 : 0);
      look();
      step();
      if (m_halted != 0) halted_cycles++;
      if (halted_cycles >= 4) begin
        pulse_reset();
        halted_cycles = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
